// File: rtl/sdr_data_path_pipe.sv
// sdr_data_path_pipe: SDRAM DQ/DQM data path with a write alignment pipe,
// a CAS-latency read-return tracker and a sticky turnaround-conflict flag.
//
// Ports:
//   CLK, RESET_N              clock, async active-low reset
//   DATAIN, DM, WR_EN         host write beat (DM bit 1 = byte masked)
//   RD_CMD                    pulse coincident with the READ command
//   DQIN                      data sampled from the DQ pins
//   CLR_ERR                   clears BUS_CONFLICT (a new set wins)
//   DQOUT, DQM, DQ_OE         pin-side write data, masks, tristate enable
//   RDATA, RDATA_VALID        captured read word and its one-cycle strobe
//   BUS_CONFLICT              sticky flag: read capture while DQ driven
//
// Optional feature: define SDR_DP_DQIN_REG_EN to register DQIN in an input
// flop first; the read return then arrives one cycle later.

module sdr_data_path_pipe #(
    parameter int DATA_W    = 16,
    parameter int DM_W      = DATA_W / 8,
    parameter int WR_LAT    = 1,
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] DATAIN,
    input  logic [DM_W-1:0]   DM,
    input  logic              WR_EN,
    input  logic              RD_CMD,
    input  logic [DATA_W-1:0] DQIN,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] DQOUT,
    output logic [DM_W-1:0]   DQM,
    output logic              DQ_OE,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_VALID,
    output logic              BUS_CONFLICT
);

    localparam int CW = $clog2(BURST_LEN + 1);

`ifdef SDR_DP_DQIN_REG_EN
    localparam int TOK_D = CAS_LAT + 1;
`else
    localparam int TOK_D = CAS_LAT;
`endif

    // ---------------- write pipeline ----------------
    // Data/mask stages only load on a valid beat so DQOUT holds the last
    // written word between writes instead of tracking idle DATAIN.
    logic [DATA_W-1:0] wd_q [WR_LAT];
    logic [DM_W-1:0]   wm_q [WR_LAT];
    logic [WR_LAT-1:0] we_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            we_q <= '0;
            for (int i = 0; i < WR_LAT; i++) begin
                wd_q[i] <= '0;
                wm_q[i] <= '1;
            end
        end else begin
            we_q[0] <= WR_EN;
            if (WR_EN) begin
                wd_q[0] <= DATAIN;
                wm_q[0] <= DM;
            end
            for (int i = 1; i < WR_LAT; i++) begin
                we_q[i] <= we_q[i-1];
                if (we_q[i-1]) begin
                    wd_q[i] <= wd_q[i-1];
                    wm_q[i] <= wm_q[i-1];
                end
            end
        end
    end

    assign DQ_OE = we_q[WR_LAT-1];
    assign DQOUT = wd_q[WR_LAT-1];
    assign DQM   = DQ_OE ? wm_q[WR_LAT-1] : '1;

    // ---------------- read burst generator ----------------
    logic [CW-1:0] burst_cnt_q;
    logic [CW-1:0] burst_cnt_d;
    logic          rd_active;

    // A new RD_CMD reloads the count, truncating any running burst.
    always_comb begin
        burst_cnt_d = '0;
        rd_active   = 1'b0;
        if (RD_CMD) begin
            burst_cnt_d = CW'(BURST_LEN);
            rd_active   = 1'b1;
        end else if (burst_cnt_q > CW'(1)) begin
            burst_cnt_d = burst_cnt_q - CW'(1);
            rd_active   = 1'b1;
        end
    end

    // ---------------- read return ----------------
    logic [TOK_D-1:0]  tok_q;
    logic              tok_exit;
    logic [DATA_W-1:0] cap_src;
    logic              oe_cmp;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              conflict_q;
    logic              conflict_d;

    assign tok_exit = tok_q[TOK_D-1];

`ifdef SDR_DP_DQIN_REG_EN
    logic [DATA_W-1:0] dqin_q;
    logic              oe_q;

    // The captured word was on the pins one cycle before the token
    // exits, so the conflict test uses the DQ_OE of that cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dqin_q <= '0;
            oe_q   <= 1'b0;
        end else begin
            dqin_q <= DQIN;
            oe_q   <= DQ_OE;
        end
    end

    assign cap_src = dqin_q;
    assign oe_cmp  = oe_q;
`else
    assign cap_src = DQIN;
    assign oe_cmp  = DQ_OE;
`endif

    // Set has priority over a coincident clear.
    assign conflict_d = (tok_exit & oe_cmp) | (conflict_q & ~CLR_ERR);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            burst_cnt_q <= '0;
            tok_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            tok_q       <= {tok_q[TOK_D-2:0], rd_active};
            rvalid_q    <= tok_exit;
            if (tok_exit) begin
                rdata_q <= cap_src;
            end
            conflict_q  <= conflict_d;
        end
    end

    assign RDATA        = rdata_q;
    assign RDATA_VALID  = rvalid_q;
    assign BUS_CONFLICT = conflict_q;

endmodule

// File: tb/tb_sdr_data_path_pipe.sv
// tb_sdr_data_path_pipe: scoreboard bench for sdr_data_path_pipe.
// Stimulus program per cycle; expected beats queued as they are driven.

module tb_sdr_data_path_pipe;

    localparam int DATA_W    = 16;
    localparam int DM_W      = DATA_W / 8;
    localparam int WR_LAT    = 1;
    localparam int CAS_LAT   = 3;
    localparam int BURST_LEN = 4;
    localparam int N         = 100;

`ifdef SDR_DP_DQIN_REG_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    localparam logic [DM_W-1:0] DM_ONES = '1;

    logic              CLK;
    logic              RESET_N;
    logic [DATA_W-1:0] DATAIN;
    logic [DM_W-1:0]   DM;
    logic              WR_EN;
    logic              RD_CMD;
    logic [DATA_W-1:0] DQIN;
    logic              CLR_ERR;
    logic [DATA_W-1:0] DQOUT;
    logic [DM_W-1:0]   DQM;
    logic              DQ_OE;
    logic [DATA_W-1:0] RDATA;
    logic              RDATA_VALID;
    logic              BUS_CONFLICT;

    sdr_data_path_pipe #(
        .DATA_W    (DATA_W),
        .WR_LAT    (WR_LAT),
        .CAS_LAT   (CAS_LAT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DATAIN       (DATAIN),
        .DM           (DM),
        .WR_EN        (WR_EN),
        .RD_CMD       (RD_CMD),
        .DQIN         (DQIN),
        .CLR_ERR      (CLR_ERR),
        .DQOUT        (DQOUT),
        .DQM          (DQM),
        .DQ_OE        (DQ_OE),
        .RDATA        (RDATA),
        .RDATA_VALID  (RDATA_VALID),
        .BUS_CONFLICT (BUS_CONFLICT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    bit                wr_s   [N];
    bit                rd_s   [N];
    bit                clr_s  [N];
    logic [DATA_W-1:0] din_s  [N];
    logic [DM_W-1:0]   dm_s   [N];
    bit                act    [N];
    bit                exp_oe [N];
    bit                exp_v  [N];
    bit                exp_cf [N];

    logic [DATA_W+DM_W-1:0] wq [$];
    logic [DATA_W-1:0]      rq [$];
    logic [DATA_W+DM_W-1:0] we;
    logic [DATA_W-1:0]      last_wd;
    logic [DATA_W-1:0]      last_rd;

    function automatic bit oe_at(input int i);
        return (i >= 0) ? exp_oe[i] : 1'b0;
    endfunction

    task automatic build_program();
        int cnt;
        int a;
        for (int t = 0; t < N; t++) begin
            wr_s[t]  = 1'b0;
            rd_s[t]  = 1'b0;
            clr_s[t] = 1'b0;
            din_s[t] = DATA_W'($urandom);
            dm_s[t]  = DM_W'($urandom);
        end
        wr_s[0] = 1'b1; din_s[0] = 16'hA5C3; dm_s[0] = 2'b01;
        rd_s[6] = 1'b1;
        rd_s[16] = 1'b1; rd_s[18] = 1'b1;
        rd_s[30] = 1'b1; wr_s[32] = 1'b1; clr_s[38] = 1'b1;
        rd_s[44] = 1'b1; wr_s[46] = 1'b1;
        clr_s[47] = 1'b1; clr_s[52] = 1'b1;
        for (int t = 56; t < 64; t++) wr_s[t] = 1'b1;
        for (int t = 64; t < 90; t++) begin
            wr_s[t]  = ($urandom_range(0, 1) == 1);
            rd_s[t]  = ($urandom_range(0, 4) == 0);
            clr_s[t] = ($urandom_range(0, 5) == 0);
        end
        cnt = 0;
        for (int t = 0; t < N; t++) begin
            if (rd_s[t]) begin
                act[t] = 1'b1; cnt = BURST_LEN;
            end else if (cnt > 1) begin
                act[t] = 1'b1; cnt--;
            end else begin
                act[t] = 1'b0; cnt = 0;
            end
        end
        for (int t = 0; t < N; t++) begin
            exp_oe[t] = (t >= WR_LAT) ? wr_s[t-WR_LAT] : 1'b0;
        end
        for (int t = 0; t < N; t++) begin
            a = t - 1 - CAS_LAT - PIPE;
            exp_v[t] = (a >= 0) ? act[a] : 1'b0;
            if (t == 0) exp_cf[t] = 1'b0;
            else exp_cf[t] = (exp_v[t] & oe_at(t - 1 - PIPE)) |
                             (exp_cf[t-1] & ~clr_s[t-1]);
        end
    endtask

    task automatic chk_reset_outputs(input string sfx);
        chk({"rst_dqout", sfx}, 32'(DQOUT), 32'(0));
        chk({"rst_dqm", sfx}, 32'(DQM), 32'(DM_ONES));
        chk({"rst_oe", sfx}, 32'(DQ_OE), 32'(0));
        chk({"rst_rdata", sfx}, 32'(RDATA), 32'(0));
        chk({"rst_valid", sfx}, 32'(RDATA_VALID), 32'(0));
        chk({"rst_conf", sfx}, 32'(BUS_CONFLICT), 32'(0));
    endtask

    initial begin
        RESET_N = 1'b0;
        DATAIN  = '0; DM = '0; WR_EN = 1'b0; RD_CMD = 1'b0;
        DQIN    = '0; CLR_ERR = 1'b0;
        last_wd = '0;
        last_rd = '0;
        build_program();

        // inputs toggle while reset is held
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            DATAIN  = DATA_W'($urandom);
            DM      = DM_W'($urandom);
            WR_EN   = 1'b1;
            RD_CMD  = 1'b1;
            DQIN    = DATA_W'($urandom);
            CLR_ERR = 1'b0;
            @(negedge CLK);
            chk_reset_outputs("_hold");
        end
        DATAIN = '0; DM = '0; WR_EN = 1'b0; RD_CMD = 1'b0; DQIN = '0;
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int t = 0; t < N; t++) begin
            @(posedge CLK); #1;
            WR_EN   = wr_s[t];
            DATAIN  = din_s[t];
            DM      = dm_s[t];
            RD_CMD  = rd_s[t];
            CLR_ERR = clr_s[t];
            DQIN    = DATA_W'(32'h1000 + t);
            if (wr_s[t]) wq.push_back({din_s[t], dm_s[t]});
            if (t >= CAS_LAT && act[t-CAS_LAT])
                rq.push_back(DATA_W'(32'h1000 + t));
            @(negedge CLK);
            chk("dq_oe", 32'(DQ_OE), 32'(exp_oe[t]));
            if (DQ_OE) begin
                if (wq.size() == 0) begin
                    chk("wq_empty", 32'(1), 32'(0));
                end else begin
                    we = wq.pop_front();
                    chk("dqout", 32'(DQOUT), 32'(we[DATA_W+DM_W-1:DM_W]));
                    chk("dqm", 32'(DQM), 32'(we[DM_W-1:0]));
                    last_wd = we[DATA_W+DM_W-1:DM_W];
                end
            end else begin
                chk("dqm_idle", 32'(DQM), 32'(DM_ONES));
                chk("dqout_hold", 32'(DQOUT), 32'(last_wd));
            end
            chk("rvalid", 32'(RDATA_VALID), 32'(exp_v[t]));
            if (RDATA_VALID) begin
                if (rq.size() == 0) begin
                    chk("rq_empty", 32'(1), 32'(0));
                end else begin
                    last_rd = rq.pop_front();
                    chk("rdata", 32'(RDATA), 32'(last_rd));
                end
            end else begin
                chk("rdata_hold", 32'(RDATA), 32'(last_rd));
            end
            chk("conflict", 32'(BUS_CONFLICT), 32'(exp_cf[t]));
        end
        chk("wq_drained", 32'(wq.size()), 32'(0));

        // mid-cycle async reset with a read burst and writes in flight
        @(posedge CLK); #1;
        RD_CMD = 1'b1; CLR_ERR = 1'b0; WR_EN = 1'b0;
        @(posedge CLK); #1;
        RD_CMD = 1'b0;
        @(posedge CLK); #1;
        WR_EN = 1'b1; DATAIN = 16'h5A5A; DM = '0;
        repeat (2 + PIPE) @(posedge CLK);
        #3;
        chk("pre_rst_valid", 32'(RDATA_VALID), 32'(1));
        chk("pre_rst_conf", 32'(BUS_CONFLICT), 32'(1));
        chk("pre_rst_oe", 32'(DQ_OE), 32'(1));
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("_async");
        WR_EN = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("post_rst_valid", 32'(RDATA_VALID), 32'(0));
            chk("post_rst_oe", 32'(DQ_OE), 32'(0));
            chk("post_rst_conf", 32'(BUS_CONFLICT), 32'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdr_data_path_pipe.md
Name: sdr_data_path_pipe

Overview:
Parametrised SDRAM data path for the SDRAM controller. It sits between the host/controller command logic and the SDRAM DQ/DQM pins.
- Write path: data, mask and output-enable are aligned to the command path through a configurable pipeline.
- Read path: the CAS-latency read-return window is tracked per burst, and returned data is captured with a valid strobe.
- Bus-turnaround conflicts between the two paths are detected.

Parameters:
DATA_W, 16, SDRAM DQ width in bits; must be a multiple of 8
DM_W, DATA_W/8, byte-mask width (derived; do not override)
WR_LAT, 1, write pipeline depth in cycles; legal 1..4
CAS_LAT, 3, cycles from RD_CMD to first read word at DQIN; legal 2..3
BURST_LEN, 4, words per read burst; legal 1, 2, 4, 8

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
DATAIN  in  DATA_W  write data from host
DM  in  DM_W  host byte masks (1 = masked)
WR_EN  in  1  DATAIN/DM are a valid write beat this cycle
RD_CMD  in  1  one-cycle pulse, same cycle the READ command is issued
DQIN  in  DATA_W  data sampled from SDRAM DQ pins
CLR_ERR  in  1  clears BUS_CONFLICT
DQOUT  out  DATA_W  write data to DQ pins
DQM  out  DM_W  SDRAM data-mask outputs
DQ_OE  out  1  DQ tristate enable (1 = drive)
RDATA  out  DATA_W  captured read data
RDATA_VALID  out  1  RDATA holds a valid read word this cycle
BUS_CONFLICT  out  1  sticky turnaround-conflict flag

Behaviour:
Reset (async assert, sync release): every pipeline stage and output is cleared to the values below, and all internal counters and tokens are cleared.
- DQOUT=0, DQM=all ones, DQ_OE=0, RDATA=0, RDATA_VALID=0, BUS_CONFLICT=0.
- Asserting reset mid-burst or mid-write discards all in-flight beats; no partial output follows deassertion.

Write pipeline:
- {DATAIN, DM, WR_EN} pass through WR_LAT register stages.
- Final stage drives DQOUT, DQ_OE (= delayed WR_EN) and DQM.
- DQM = delayed DM when delayed WR_EN=1, else all ones.
- DQOUT holds its last value when not writing (no glitching to 0).
- Latency is exactly WR_LAT cycles. Back-to-back writes are accepted every cycle with no bubbles.

Read burst generator:
- burst_cnt, width clog2(BURST_LEN+1), resets to 0.
- RD_CMD=1: burst_cnt <= BURST_LEN, and rd_active=1 this cycle.
- Otherwise, if burst_cnt>1: burst_cnt decrements and rd_active=1.
- Otherwise: burst_cnt <= 0 and rd_active=0.
- A new RD_CMD during an active burst truncates the old burst and restarts the count (SDRAM read-interrupt semantics).

Read return:
- rd_active enters a CAS_LAT-deep token shift register.
- When the token exits: RDATA <= DQIN and RDATA_VALID=1 for one cycle. RDATA holds its value otherwise.
- A single RD_CMD therefore yields BURST_LEN consecutive valid beats. The first beat is registered at edge CAS_LAT after RD_CMD, so RDATA_VALID is visible CAS_LAT+1 cycles after the RD_CMD cycle.

Conflict detection:
- BUS_CONFLICT is set when the read token is about to capture (token exiting) in the same cycle DQ_OE=1.
- The write still proceeds and the read beat is still flagged valid; the flag exists for debug only.
- BUS_CONFLICT stays set until CLR_ERR=1. If set and clear occur in the same cycle, set wins.

Simultaneous WR_EN and RD_CMD: both are accepted independently; any conflict is reported only via BUS_CONFLICT.

Optional Feature:
Macro SDR_DP_DQIN_REG_EN.
- Defined: DQIN is first registered in an input flop (intended for IOB placement). The read token pipeline is lengthened by one, so RDATA_VALID is visible CAS_LAT+2 cycles after the RD_CMD cycle. Conflict detection compares against the DQ_OE value one cycle earlier, matching when the data was on the pins. The input flop resets to 0.
- Undefined: DQIN is sampled directly as described in Behaviour; no extra latency.

Test Plan:
- Reset check: hold RESET_N=0, toggle all inputs -> DQM=2'b11, DQ_OE=0, RDATA_VALID=0, BUS_CONFLICT=0. Assert RESET_N asynchronously mid-cycle -> outputs clear immediately.
- Write latency, defaults: WR_EN=1, DATAIN=16'hA5C3, DM=2'b01 at cycle 0, WR_EN=0 at cycle 1 -> at cycle 1 DQOUT=A5C3, DQM=01, DQ_OE=1. At cycle 2: DQ_OE=0, DQM=11, DQOUT still A5C3. Repeat with WR_LAT=3 -> appears at cycle 3.
- Read burst: RD_CMD pulse at cycle 0, DQIN=16'h1000+cycle -> RDATA_VALID high in cycles 4..7, RDATA = 1003, 1004, 1005, 1006.
- Read interrupt: RD_CMD at cycles 0 and 2 -> 6 valid beats in cycles 4..9 with no gap.
- Conflict: RD_CMD at cycle 0, WR_EN at cycle 2 -> BUS_CONFLICT rises at cycle 4 and holds. CLR_ERR at cycle 8 -> low at cycle 9. CLR_ERR coincident with a new conflict -> stays 1.
- SDR_DP_DQIN_REG_EN defined: RD_CMD at cycle 0 with DQIN=16'h1000+cycle -> RDATA_VALID in cycles 5..8, RDATA = 1003..1006.
